sdr_cmd_arb: RTL and testbench

Top-level scheduler for the SDRAM command bus. It owns the auto-refresh interval timer and decides which engine drives nRAS/nCAS/nWE/BA/A. The engines are the refresh engine, the write engine (sdr_wr), and the read engine. Refresh has strict priority; reads and writes are granted round-robin. One engine owns the bus at a time, from its start pulse until its exit pulse.

---
 rtl/sdr_cmd_arb.sv | 176 +++++++++++++++++
 tb/tb_sdr_cmd_arb.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sdr_cmd_arb.sv
// SDRAM command-bus scheduler: refresh interval timer, strict-priority refresh,
// round-robin read/write grants, and a combinational mux of the owning engine's command.
module sdr_cmd_arb #(
  parameter int REF_INTERVAL = 1250,
  parameter int MAX_PEND     = 7
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        init_done,
  input  logic        wr_req,
  output logic        wr_ack,
  input  logic        rd_req,
  output logic        rd_ack,
  output logic        wr_start,
  input  logic        wr_exit,
  output logic        rd_start,
  input  logic        rd_exit,
  output logic        ref_start,
  input  logic        ref_exit,
  input  logic [2:0]  wr_cmd,
  input  logic [2:0]  rd_cmd,
  input  logic [2:0]  ref_cmd,
  input  logic [1:0]  wr_ba,
  input  logic [1:0]  rd_ba,
  input  logic [1:0]  ref_ba,
  input  logic [12:0] wr_a,
  input  logic [12:0] rd_a,
  input  logic [12:0] ref_a,
  output logic [2:0]  sdr_cmd,
  output logic [1:0]  sdr_ba,
  output logic [12:0] sdr_a,
  output logic [1:0]  owner,
  output logic        ref_overflow
);

  localparam int TW = $clog2(REF_INTERVAL);
  localparam logic [TW-1:0] TIMER_LAST = TW'(REF_INTERVAL - 1);
  localparam logic [2:0]    PEND_MAX   = 3'(MAX_PEND);

  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_REF  = 2'd1;
  localparam logic [1:0] OWN_WR   = 2'd2;
  localparam logic [1:0] OWN_RD   = 2'd3;

  typedef enum logic [2:0] {S_INIT, S_IDLE, S_REF, S_WR, S_RD} state_t;

  state_t        state_q, state_d;
  logic [1:0]    owner_q, owner_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [2:0]    ref_pend_q, ref_pend_d;
  logic          rr_last_q, rr_last_d;
  logic          ref_overflow_q, ref_overflow_d;

  logic timer_wrap;
  logic pend_dec;
  logic grant_wr;
  logic grant_rd;

  assign timer_wrap = (state_q != S_INIT) && (timer_q == TIMER_LAST);

  // Contention resolves away from whichever side rr_last says went last.
  assign grant_wr = wr_req && (!rd_req || rr_last_q);
  assign grant_rd = rd_req && (!wr_req || !rr_last_q);

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    rr_last_d = rr_last_q;
    ref_start = 1'b0;
    wr_start  = 1'b0;
    rd_start  = 1'b0;
    pend_dec  = 1'b0;

    case (state_q)
      S_INIT: begin
        if (init_done) state_d = S_IDLE;
      end
      S_IDLE: begin
        if (ref_pend_q != 3'd0) begin
          ref_start = 1'b1;
          state_d   = S_REF;
          owner_d   = OWN_REF;
        end else if (grant_wr) begin
          wr_start = 1'b1;
          state_d  = S_WR;
          owner_d  = OWN_WR;
          if (rd_req) rr_last_d = 1'b0;
        end else if (grant_rd) begin
          rd_start = 1'b1;
          state_d  = S_RD;
          owner_d  = OWN_RD;
          if (wr_req) rr_last_d = 1'b1;
        end
      end
      S_REF: begin
        if (ref_exit) begin
          pend_dec = 1'b1;
          state_d  = S_IDLE;
          owner_d  = OWN_NONE;
        end
      end
      S_WR: begin
        if (wr_exit) begin
          state_d = S_IDLE;
          owner_d = OWN_NONE;
        end
      end
      S_RD: begin
        if (rd_exit) begin
          state_d = S_IDLE;
          owner_d = OWN_NONE;
        end
      end
      default: begin
        state_d = S_INIT;
        owner_d = OWN_NONE;
      end
    endcase
  end

  // A wrap coinciding with ref_start is absorbed by the refresh being launched.
  always_comb begin
    timer_d        = timer_q + TW'(1);
    ref_pend_d     = ref_pend_q;
    ref_overflow_d = ref_overflow_q;

    if (state_q == S_INIT || timer_wrap) timer_d = '0;

    if (timer_wrap && !ref_start && !pend_dec) begin
      if (ref_pend_q == PEND_MAX) begin
        ref_overflow_d = 1'b1;
      end else begin
        ref_pend_d = ref_pend_q + 3'd1;
        if (ref_pend_q + 3'd1 == PEND_MAX) ref_overflow_d = 1'b1;
      end
    end else if (pend_dec && !timer_wrap) begin
      ref_pend_d = ref_pend_q - 3'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_INIT;
      owner_q        <= OWN_NONE;
      timer_q        <= '0;
      ref_pend_q     <= 3'd0;
      rr_last_q      <= 1'b0;
      ref_overflow_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      owner_q        <= owner_d;
      timer_q        <= timer_d;
      ref_pend_q     <= ref_pend_d;
      rr_last_q      <= rr_last_d;
      ref_overflow_q <= ref_overflow_d;
    end
  end

  always_comb begin
    sdr_cmd = 3'b111;
    sdr_ba  = 2'd0;
    sdr_a   = 13'd0;
    case (owner_q)
      OWN_REF: begin sdr_cmd = ref_cmd; sdr_ba = ref_ba; sdr_a = ref_a; end
      OWN_WR:  begin sdr_cmd = wr_cmd;  sdr_ba = wr_ba;  sdr_a = wr_a;  end
      OWN_RD:  begin sdr_cmd = rd_cmd;  sdr_ba = rd_ba;  sdr_a = rd_a;  end
      default: begin sdr_cmd = 3'b111;  sdr_ba = 2'd0;   sdr_a = 13'd0; end
    endcase
  end

  assign wr_ack       = wr_start;
  assign rd_ack       = rd_start;
  assign owner        = owner_q;
  assign ref_overflow = ref_overflow_q;

endmodule

// File: tb/tb_sdr_cmd_arb.sv
// Directed bench for sdr_cmd_arb: grants are scored against a queue of
// expected (engine, cycle) pairs; bus/owner/counter state is checked inline.
module tb_sdr_cmd_arb;

  logic        clk = 1'b0;
  logic        rst_n, init_done;
  logic        wr_req, wr_ack, rd_req, rd_ack;
  logic        wr_start, wr_exit, rd_start, rd_exit, ref_start, ref_exit;
  logic [2:0]  wr_cmd, rd_cmd, ref_cmd, sdr_cmd;
  logic [1:0]  wr_ba, rd_ba, ref_ba, sdr_ba, owner;
  logic [12:0] wr_a, rd_a, ref_a, sdr_a;
  logic        ref_overflow;

  always #5 clk = ~clk;

  sdr_cmd_arb dut (
    .clk(clk), .rst_n(rst_n), .init_done(init_done),
    .wr_req(wr_req), .wr_ack(wr_ack), .rd_req(rd_req), .rd_ack(rd_ack),
    .wr_start(wr_start), .wr_exit(wr_exit), .rd_start(rd_start), .rd_exit(rd_exit),
    .ref_start(ref_start), .ref_exit(ref_exit),
    .wr_cmd(wr_cmd), .rd_cmd(rd_cmd), .ref_cmd(ref_cmd),
    .wr_ba(wr_ba), .rd_ba(rd_ba), .ref_ba(ref_ba),
    .wr_a(wr_a), .rd_a(rd_a), .ref_a(ref_a),
    .sdr_cmd(sdr_cmd), .sdr_ba(sdr_ba), .sdr_a(sdr_a),
    .owner(owner), .ref_overflow(ref_overflow)
  );

  localparam int K_REF = 1, K_WR = 2, K_RD = 3, K_BAD = 7;

  typedef struct {
    int kind;
    int cyc;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s @cyc %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expect_grant(input int kind, input int at);
    exp_t e;
    e.kind = kind;
    e.cyc  = at;
    exp_q.push_back(e);
  endtask

  // Monitor: every grant pulse must match the head of the expected queue.
  initial begin
    forever begin
      @(negedge clk);
      if (ref_start | wr_start | wr_ack | rd_start | rd_ack) begin
        int   kind;
        exp_t e;
        case ({ref_start, wr_start, wr_ack, rd_start, rd_ack})
          5'b10000: kind = K_REF;
          5'b01100: kind = K_WR;
          5'b00011: kind = K_RD;
          default:  kind = K_BAD;
        endcase
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_grant @cyc %0d: got kind %0d, expected none", cyc, kind);
        end else begin
          e = exp_q.pop_front();
          if (kind != e.kind || cyc != e.cyc) begin
            miscompares++;
            $display("FAIL grant: got kind %0d @cyc %0d, expected kind %0d @cyc %0d",
                     kind, cyc, e.kind, e.cyc);
          end
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0; init_done = 1'b0;
    wr_req = 1'b0; rd_req = 1'b0;
    wr_exit = 1'b0; rd_exit = 1'b0; ref_exit = 1'b0;
    wr_cmd = 3'b100; rd_cmd = 3'b101; ref_cmd = 3'b001;
    wr_ba = 2'd2; rd_ba = 2'd1; ref_ba = 2'd3;
    wr_a = 13'h0AAA; rd_a = 13'h1555; ref_a = 13'h0123;

    // Reset state
    wait_cyc(1);
    check("rst_owner", 32'(owner), 32'd0);
    check("rst_sdr_cmd", 32'(sdr_cmd), 32'b111);
    check("rst_sdr_ba", 32'(sdr_ba), 32'd0);
    check("rst_sdr_a", 32'(sdr_a), 32'd0);
    check("rst_pulses", 32'({ref_start, wr_start, wr_ack, rd_start, rd_ack}), 32'd0);
    check("rst_overflow", 32'(ref_overflow), 32'd0);
    wait_cyc(3);
    rst_n = 1'b1;

    // First refresh: idle from cycle 11, wrap at timer 1249 -> ref_start at 1261
    wait_cyc(10);
    init_done = 1'b1;
    expect_grant(K_REF, 1261);
    wait_cyc(1262);
    check("ref1_owner", 32'(owner), 32'd1);
    check("ref1_mux_cmd", 32'(sdr_cmd), 32'b001);
    wait_cyc(1269);
    ref_exit = 1'b1;
    wait_cyc(1270);
    ref_exit = 1'b0;
    check("ref1_owner_back", 32'(owner), 32'd0);
    check("ref1_pend_zero", 32'(dut.ref_pend_q), 32'd0);

    // Contention with rr_last=0: read first, then write after one idle cycle
    wr_req = 1'b1; rd_req = 1'b1;
    expect_grant(K_RD, 1270);
    wait_cyc(1271);
    rd_req = 1'b0;
    check("rd_owner", 32'(owner), 32'd3);
    check("rd_mux_a", 32'(sdr_a), 32'h1555);
    wait_cyc(1275);
    rd_exit = 1'b1;
    expect_grant(K_WR, 1276);
    wait_cyc(1276);
    rd_exit = 1'b0;
    wait_cyc(1277);
    wr_req = 1'b0;
    check("wr_owner", 32'(owner), 32'd2);
    check("wr_mux_cmd", 32'(sdr_cmd), 32'b100);
    check("wr_mux_ba", 32'(sdr_ba), 32'd2);
    check("wr_mux_a", 32'(sdr_a), 32'h0AAA);

    // Non-owner exits are ignored
    wait_cyc(1278);
    rd_exit = 1'b1; ref_exit = 1'b1;
    wait_cyc(1279);
    rd_exit = 1'b0; ref_exit = 1'b0;
    check("foreign_exit_owner", 32'(owner), 32'd2);
    check("foreign_exit_pend", 32'(dut.ref_pend_q), 32'd0);

    // Timer wraps at 2510 while writing; refresh waits, then beats a pending read
    wait_cyc(2400);
    rd_req = 1'b1;
    wait_cyc(2600);
    check("wr_hold_owner", 32'(owner), 32'd2);
    check("wr_hold_pend", 32'(dut.ref_pend_q), 32'd1);
    wait_cyc(2810);
    wr_exit = 1'b1;
    expect_grant(K_REF, 2811);
    wait_cyc(2811);
    wr_exit = 1'b0;
    wait_cyc(2812);
    check("ref2_owner", 32'(owner), 32'd1);
    wait_cyc(2815);
    ref_exit = 1'b1;
    expect_grant(K_RD, 2816);
    wait_cyc(2816);
    ref_exit = 1'b0;
    wait_cyc(2817);
    rd_req = 1'b0;
    wait_cyc(2820);
    rd_exit = 1'b1;
    wait_cyc(2821);
    rd_exit = 1'b0;
    check("rd2_owner_back", 32'(owner), 32'd0);

    // Saturation: refresh at 3761 held; wraps bring pend to 7 at 11261
    expect_grant(K_REF, 3761);
    wait_cyc(3762);
    check("ref3_owner", 32'(owner), 32'd1);
    wait_cyc(11255);
    check("pre_sat_pend", 32'(dut.ref_pend_q), 32'd6);
    check("pre_sat_overflow", 32'(ref_overflow), 32'd0);
    wait_cyc(11262);
    check("sat_pend", 32'(dut.ref_pend_q), 32'd7);
    check("sat_overflow", 32'(ref_overflow), 32'd1);
    wait_cyc(12520);
    check("sat_hold_pend", 32'(dut.ref_pend_q), 32'd7);
    for (int i = 0; i < 7; i++) begin
      if (i < 6) expect_grant(K_REF, 12601 + 3 * i);
      wait_cyc(12600 + 3 * i);
      ref_exit = 1'b1;
      wait_cyc(12601 + 3 * i);
      ref_exit = 1'b0;
    end
    wait_cyc(12620);
    check("drain_pend", 32'(dut.ref_pend_q), 32'd0);
    check("drain_overflow_sticky", 32'(ref_overflow), 32'd1);
    check("drain_owner", 32'(owner), 32'd0);

    // Reset in the middle of a write
    wait_cyc(12625);
    wr_req = 1'b1;
    expect_grant(K_WR, 12625);
    wait_cyc(12626);
    wr_req = 1'b0;
    check("wr3_mux_cmd", 32'(sdr_cmd), 32'b100);
    wait_cyc(12630);
    rst_n = 1'b0; init_done = 1'b0;
    #1;
    check("mid_rst_sdr_cmd", 32'(sdr_cmd), 32'b111);
    check("mid_rst_owner", 32'(owner), 32'd0);
    check("mid_rst_pulses", 32'({ref_start, wr_start, wr_ack, rd_start, rd_ack}), 32'd0);
    check("mid_rst_overflow", 32'(ref_overflow), 32'd0);
    check("mid_rst_pend", 32'(dut.ref_pend_q), 32'd0);
    wait_cyc(12633);
    rst_n = 1'b1;
    wait_cyc(12636);
    wr_req = 1'b1;
    wait_cyc(12639);
    check("init_hold_owner", 32'(owner), 32'd0);
    check("init_hold_sdr_cmd", 32'(sdr_cmd), 32'b111);
    wait_cyc(12640);
    init_done = 1'b1;
    expect_grant(K_WR, 12641);
    wait_cyc(12642);
    wr_req = 1'b0;
    check("post_rst_wr_owner", 32'(owner), 32'd2);
    wait_cyc(12645);
    wr_exit = 1'b1;
    wait_cyc(12646);
    wr_exit = 1'b0;
    wait_cyc(12655);
    check("end_owner", 32'(owner), 32'd0);
    check("grants_outstanding", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
